// File: rtl/matmul_engine.sv
// rtl/matmul_engine.sv - self-sequenced unsigned matrix multiply C = A * B with scaled, saturated readout
module matmul_engine #(
   parameter int DATA_WIDTH = 8,
   parameter int M          = 4,
   parameter int K          = 4,
   parameter int N          = 4,
   parameter int ACC_WIDTH  = 18,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic                  wr_sel,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  start,
   input  logic [2:0]            shift_cnt,
   output logic                  busy,
   output logic                  done,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  rd_sat
);

   localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   MK_SZ  = (ADDR_WIDTH + 1)'(M * K);
   localparam logic [ADDR_WIDTH:0]   KN_SZ  = (ADDR_WIDTH + 1)'(K * N);
   localparam logic [ADDR_WIDTH:0]   MN_SZ  = (ADDR_WIDTH + 1)'(M * N);
   localparam logic [ADDR_WIDTH-1:0] K_A    = ADDR_WIDTH'(K);
   localparam logic [ADDR_WIDTH-1:0] N_A    = ADDR_WIDTH'(N);
   localparam logic [ADDR_WIDTH-1:0] M_LAST = ADDR_WIDTH'(M - 1);
   localparam logic [ADDR_WIDTH-1:0] K_LAST = ADDR_WIDTH'(K - 1);
   localparam logic [ADDR_WIDTH-1:0] N_LAST = ADDR_WIDTH'(N - 1);

   typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_WRITE, S_DONE} state_t;
   state_t state, state_nxt;

   logic [DATA_WIDTH-1:0] a_mem [MEM_DEPTH];
   logic [DATA_WIDTH-1:0] b_mem [MEM_DEPTH];
   logic [ACC_WIDTH-1:0]  c_mem [MEM_DEPTH];

   logic [ADDR_WIDTH-1:0] i_cnt, j_cnt, k_cnt;
   logic [ADDR_WIDTH-1:0] a_addr, b_addr, c_addr;
   logic [DATA_WIDTH-1:0] a_q, b_q;
   logic [ACC_WIDTH-1:0]  acc, prod, c_shifted;
   logic [2:0]            shift_q;
   logic                  mac_d, first_d, wr_ok, last_elem, rd_in_range, rd_clip;

   assign a_addr    = i_cnt * K_A + k_cnt;
   assign b_addr    = k_cnt * N_A + j_cnt;
   assign c_addr    = i_cnt * N_A + j_cnt;
   assign last_elem = (i_cnt == M_LAST) && (j_cnt == N_LAST);
   assign wr_ok     = (state == S_IDLE) && wr_en &&
                      ({1'b0, wr_addr} < (wr_sel ? KN_SZ : MK_SZ));
   assign prod      = ACC_WIDTH'(a_q) * ACC_WIDTH'(b_q);
   assign busy      = (state == S_MAC) || (state == S_DRAIN) || (state == S_WRITE);
   assign done      = (state == S_DONE);

   assign rd_in_range = ({1'b0, rd_addr} < MN_SZ);
   assign c_shifted   = c_mem[rd_addr] >> shift_q;
   assign rd_clip     = |c_shifted[ACC_WIDTH-1:DATA_WIDTH];

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_MAC;
         S_MAC:   if (k_cnt == K_LAST) state_nxt = S_DRAIN;
         S_DRAIN: state_nxt = S_WRITE;
         S_WRITE: state_nxt = last_elem ? S_DONE : S_MAC;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Operand reads land one cycle after their MAC cycle, so the accumulator
   // follows the address stream through a one-cycle delayed enable/first flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i_cnt   <= '0;
         j_cnt   <= '0;
         k_cnt   <= '0;
         acc     <= '0;
         shift_q <= '0;
         mac_d   <= 1'b0;
         first_d <= 1'b0;
      end else begin
         mac_d   <= (state == S_MAC);
         first_d <= (state == S_MAC) && (k_cnt == '0);
         if (mac_d) acc <= first_d ? prod : acc + prod;
         case (state)
            S_IDLE: if (start) begin
               shift_q <= shift_cnt;
               i_cnt   <= '0;
               j_cnt   <= '0;
               k_cnt   <= '0;
            end
            S_MAC: k_cnt <= (k_cnt == K_LAST) ? '0 : k_cnt + 1'b1;
            S_WRITE: begin
               if (j_cnt == N_LAST) begin
                  j_cnt <= '0;
                  i_cnt <= (i_cnt == M_LAST) ? '0 : i_cnt + 1'b1;
               end else begin
                  j_cnt <= j_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok && !wr_sel) a_mem[wr_addr] <= wr_data;
      if (wr_ok && wr_sel)  b_mem[wr_addr] <= wr_data;
      if (state == S_WRITE) c_mem[c_addr] <= acc;
      a_q <= a_mem[a_addr];
      b_q <= b_mem[b_addr];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_valid <= 1'b0;
         rd_sat   <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_en;
         rd_sat   <= rd_en && rd_in_range && rd_clip;
         if (rd_en) begin
            if (!rd_in_range) rd_data <= '0;
            else if (rd_clip) rd_data <= '1;
            else              rd_data <= c_shifted[DATA_WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_matmul_engine.sv
// tb/tb_matmul_engine.sv - scoreboard bench for matmul_engine against an arithmetic reference model
module tb_matmul_engine;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en, wr_sel, start, rd_en;
   logic [7:0] wr_addr, wr_data, rd_addr;
   logic [2:0] shift_cnt;
   logic       busy, done, rd_valid, rd_sat;
   logic [7:0] rd_data;

   int total = 0;
   int bad   = 0;

   typedef struct {int data; int sat;} exp_t;
   exp_t exp_q[$];

   int a_m[16];
   int b_m[16];
   int c_m[16];

   matmul_engine dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
      .wr_data(wr_data), .start(start), .shift_cnt(shift_cnt), .busy(busy),
      .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_valid(rd_valid), .rd_sat(rd_sat)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every valid read is matched against the oldest expected entry.
   always @(negedge clk) begin
      if (rst && rd_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rd_valid", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("rd_data", int'(rd_data), e.data);
            check("rd_sat", int'(rd_sat), e.sat);
         end
      end
   end

   task automatic model();
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            longint s = 0;
            for (int k = 0; k < 4; k++) s += longint'(a_m[i*4+k]) * longint'(b_m[k*4+j]);
            c_m[i*4+j] = int'(s % (longint'(1) << 18));
         end
   endtask

   task automatic load();
      for (int s = 0; s < 2; s++)
         for (int idx = 0; idx < 16; idx++) begin
            wr_en   = 1'b1;
            wr_sel  = s[0];
            wr_addr = 8'(idx);
            wr_data = 8'(s == 0 ? a_m[idx] : b_m[idx]);
            @(posedge clk); #1;
         end
      wr_en = 1'b0;
      model();
   endtask

   // Starts a run, checks busy/done every cycle through cycle 100.
   task automatic run(input int sh, input bit interfere);
      int dones = 0;
      shift_cnt = 3'(sh);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 1; cyc <= 100; cyc++) begin
         @(negedge clk);
         check("busy", int'(busy), (cyc <= 96) ? 1 : 0);
         check("done", int'(done), (cyc == 97) ? 1 : 0);
         if (done) dones++;
         if (interfere && cyc == 10) begin
            wr_en   = 1'b1;
            wr_sel  = 1'b0;
            wr_addr = 8'd0;
            wr_data = 8'(a_m[0] ^ 8'hFF);
            start   = 1'b1;
         end
         @(posedge clk); #1;
         wr_en = 1'b0;
         start = 1'b0;
      end
      check("done_pulse_count", dones, 1);
   endtask

   task automatic read_all(input int sh);
      for (int idx = 0; idx <= 16; idx++) begin
         exp_t e;
         int   v;
         int   ad;
         ad = (idx == 16) ? 200 : idx;
         v = (ad < 16) ? (c_m[ad] >> sh) : 0;
         e.sat  = (v > 255) ? 1 : 0;
         e.data = (v > 255) ? 255 : v;
         exp_q.push_back(e);
         rd_en   = 1'b1;
         rd_addr = 8'(ad);
         @(posedge clk); #1;
      end
      rd_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int sh;
      rst = 1'b0; wr_en = 0; wr_sel = 0; wr_addr = 0; wr_data = 0;
      start = 0; shift_cnt = 0; rd_en = 0; rd_addr = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_rd_valid", int'(rd_valid), 0);
      check("reset_rd_data", int'(rd_data), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      for (int x = 0; x < 16; x++) begin
         a_m[x] = (x / 4 == x % 4) ? 1 : 0;
         b_m[x] = x + 1;
      end
      load(); run(0, 0); read_all(0);

      for (int x = 0; x < 16; x++) begin a_m[x] = 2; b_m[x] = 3; end
      load(); run(3, 0); read_all(3);

      for (int x = 0; x < 16; x++) begin a_m[x] = 255; b_m[x] = 255; end
      load(); run(0, 0); read_all(0);
      run(7, 0); read_all(7);

      for (int r = 0; r < 3; r++) begin
         for (int x = 0; x < 16; x++) begin
            a_m[x] = int'($urandom_range(0, 255));
            b_m[x] = int'($urandom_range(0, 255));
         end
         sh = int'($urandom_range(0, 7));
         load(); run(sh, r == 1); read_all(sh);
      end

      // Abort mid-run: reset drops asynchronously in cycle 40.
      for (int x = 0; x < 16; x++) begin
         a_m[x] = int'($urandom_range(0, 255));
         b_m[x] = int'($urandom_range(0, 255));
      end
      load();
      shift_cnt = 3'd4;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (39) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_done", int'(done), 0);
      check("async_rst_rd_valid", int'(rd_valid), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      run(4, 0); read_all(4);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/matmul_engine.md
Name: matmul_engine

Overview:
- Self-sequenced unsigned matrix-multiply engine: C[MxN] = A[MxK] * B[KxN].
- Contains A and B operand RAMs, one multiply-accumulate (MAC) accumulator, a C result RAM and the control FSM that generates every address.
- Host side: loads A/B through a write port, pulses start, waits for done, then reads C through a read port.
- Read data is scaled by a run-time right shift and saturated to DATA_WIDTH.

Parameters:
- DATA_WIDTH, 8, operand and read-data width.
- M, 4, rows of A and C.
- K, 4, columns of A / rows of B (inner dimension).
- N, 4, columns of B and C.
- ACC_WIDTH, 18, accumulator and C-entry width. Must be >= 2*DATA_WIDTH + clog2(K) for overflow-free results.
- ADDR_WIDTH, 8, port address width. 2^ADDR_WIDTH must be >= max(M*K, K*N, M*N).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset.
- wr_en  in  1  operand write strobe.
- wr_sel  in  1  0 = write A, 1 = write B.
- wr_addr  in  ADDR_WIDTH  row-major index: A[i][k] = i*K+k, B[k][j] = k*N+j.
- wr_data  in  DATA_WIDTH  operand value.
- start  in  1  begin computation; sampled only in IDLE.
- shift_cnt  in  3  right-shift amount applied on readout; latched at accepted start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse when all of C is written.
- rd_en  in  1  C read strobe.
- rd_addr  in  ADDR_WIDTH  C[i][j] = i*N+j.
- rd_data  out  DATA_WIDTH  scaled, saturated C entry.
- rd_valid  out  1  rd_data qualifier.
- rd_sat  out  1  high with rd_valid when rd_data was clipped.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low: rst = 0 forces reset immediately, independent of clk.
- Reset values: FSM = IDLE; busy, done, rd_valid, rd_sat = 0; rd_data = 0; shift register = 0; i/j/k counters and accumulator = 0.
- RAM contents are not reset. C retains its last written values.
- Writes: accepted only in IDLE, in the same edge as wr_en. wr_en while busy is ignored, and RAM is unchanged.
- Addresses: out-of-range wr_addr (>= M*K or K*N) is ignored. Out-of-range rd_addr returns 0 with rd_valid = 1.
- Operand RAMs: synchronous read, 1-cycle latency.
- FSM states: IDLE -> MAC -> DRAIN -> WRITE -> (MAC | DONE) -> IDLE.
- IDLE: start = 1 latches shift_cnt, clears i, j, k and goes to MAC. start in any other state is ignored.
- MAC (K cycles, k = 0..K-1): issue A addr i*K+k and B addr k*N+j.
- Accumulation uses the product of the previous cycle's addresses. The first product of an element loads the accumulator (acc = p); later products add (acc = acc + p).
- Arithmetic: product is a DATA_WIDTH x DATA_WIDTH unsigned multiply, zero-extended to ACC_WIDTH. Accumulation wraps modulo 2^ACC_WIDTH.
- DRAIN (1 cycle): accumulate the final product.
- WRITE (1 cycle): C[i*N+j] <= acc.
- Counter advance after WRITE: j increments. When j wraps at N, j = 0 and i increments. When i = M-1 and j = N-1, go to DONE instead of MAC.
- DONE (1 cycle): done = 1, busy = 0, then IDLE.
- Latency: K+2 cycles per element. done is high exactly in cycle M*N*(K+2)+1 after the edge that samples start. Cycle 1 is the first MAC cycle.
- Readout: rd_en sampled at edge t. At t+1: rd_valid = 1 and rd_data = min(C >> shift, 2^DATA_WIDTH - 1). rd_sat = 1 iff clipping occurred.
- Otherwise rd_valid = 0 and rd_data holds its previous value.
- Reads during busy are allowed and return current RAM contents. There is no coherency guarantee.
- A read of the address being written in the same cycle returns the old value.
- Simultaneous wr_en and start in IDLE: the write lands, and computation sees the new value.
- Reset mid-operation: immediate return to IDLE, no done pulse. C is partially updated and its contents are undefined for the interrupted run.
- Back-to-back: start held high across DONE starts a new run on the cycle after DONE (the IDLE cycle).

Test Plan:
- Identity: A = I(4x4), B[k][j] = 4k+j+1, shift 0 -> C reads 1..16 in order, rd_sat = 0.
- Constants: A all 2, B all 3, shift 3 -> every C = 24 stored; rd_data = 3.
- Saturation: A, B all 255, shift 0 -> stored 260100; rd_data = 255, rd_sat = 1. With shift 7 -> 2032, clipped to 255, rd_sat = 1.
- Timing: start at cycle 0 with default params -> busy high cycles 1..96, done pulse exactly at cycle 97, never earlier or longer.
- Interference: wr_en to A and a second start while busy -> A unchanged, single done pulse at cycle 97, results match first-run operands.
- Reset mid-run: drop rst at cycle 40 -> busy/done/rd_valid 0 asynchronously. Restart after release completes in 97 cycles with correct C.
